// File: rtl/cpu_mem_bridge.sv
// -----------------------------------------------------------------------------
// cpu_mem_bridge
//
// Purpose:
//   Joins the core's two single-ported SRAM-style interfaces (instruction fetch
//   and data access) onto one shared memory port that uses a request /
//   address-ok / data-ok handshake. Whatever the core presents while the
//   bridge is idle is captured at one clock edge. The data access is then
//   issued first and the fetch second, with only one memory transaction
//   outstanding at a time. mem_stall freezes the core until both results
//   have come back.
//
// Optional feature (macro BRIDGE_IBUF_EN):
//   When defined, a one-entry fetch buffer (valid, word-address tag,
//   instruction) serves repeated fetches of the same word without a memory
//   access. A store to the buffered word invalidates it. When the macro is
//   undefined, no buffer state exists and every fetch goes to memory.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   inst_sram_en/addr     fetch request from the core
//   inst_sram_rdata       registered fetched word
//   data_sram_en/wen/addr/wdata
//                         data request from the core (wen != 0 means store)
//   data_sram_rdata       registered load result
//   mem_stall             core must hold all pipeline registers
//   mem_req/wr/wstrb/addr/wdata
//                         shared memory request channel
//   mem_addr_ok           request accepted this cycle
//   mem_data_ok/mem_rdata response channel
// -----------------------------------------------------------------------------
module cpu_mem_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_sram_en,
   input  logic [ADDR_W-1:0]   inst_sram_addr,
   output logic [DATA_W-1:0]   inst_sram_rdata,
   input  logic                data_sram_en,
   input  logic [DATA_W/8-1:0] data_sram_wen,
   input  logic [ADDR_W-1:0]   data_sram_addr,
   input  logic [DATA_W-1:0]   data_sram_wdata,
   output logic [DATA_W-1:0]   data_sram_rdata,
   output logic                mem_stall,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_REQ  = 3'd1,
      D_WAIT = 3'd2,
      I_REQ  = 3'd3,
      I_WAIT = 3'd4
   } state_e;

   state_e              state_q, state_d;

   logic                dPend_q, iPend_q;
   logic [ADDR_W-1:0]   dAddr_q;
   logic [STRB_W-1:0]   dWen_q;
   logic [DATA_W-1:0]   dWdata_q;
   logic [ADDR_W-1:0]   iAddr_q;
   logic [DATA_W-1:0]   instRdata_q;
   logic [DATA_W-1:0]   dataRdata_q;

   // A fetch that is served locally never becomes pending, so the state
   // machine only needs to know whether a memory fetch is required.
   logic                ibHit;
   logic                fetchToMem;

`ifdef BRIDGE_IBUF_EN
   logic                ibValid_q;
   logic [ADDR_W-3:0]   ibTag_q;
   logic [DATA_W-1:0]   ibData_q;
   logic                storeHitsTag;

   // A store captured in the same cycle as a fetch of the same word is
   // issued first, so the buffered copy is stale and must not be used.
   assign storeHitsTag = data_sram_en && (|data_sram_wen) && ibValid_q &&
                         (data_sram_addr[ADDR_W-1:2] == ibTag_q);
   assign ibHit        = inst_sram_en && ibValid_q && !storeHitsTag &&
                         (inst_sram_addr[ADDR_W-1:2] == ibTag_q);
`else
   assign ibHit        = 1'b0;
`endif

   assign fetchToMem = inst_sram_en && !ibHit;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. In IDLE the decision uses the live core inputs,
   // because they are captured at this same edge. Each REQ state holds
   // until the request is accepted. Each WAIT state holds until the
   // response arrives.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (data_sram_en) begin
               state_d = D_REQ;
            end else if (fetchToMem) begin
               state_d = I_REQ;
            end
         end
         D_REQ:  if (mem_addr_ok) state_d = D_WAIT;
         D_WAIT: if (mem_data_ok) state_d = iPend_q ? I_REQ : IDLE;
         I_REQ:  if (mem_addr_ok) state_d = I_WAIT;
         I_WAIT: if (mem_data_ok) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request outputs are driven from the captured registers only while in
   // a REQ state, so they stay stable until the request is accepted and
   // read as zero otherwise.
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_wstrb = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         D_REQ: begin
            mem_req   = dPend_q;
            mem_wr    = |dWen_q;
            mem_wstrb = dWen_q;
            mem_addr  = dAddr_q;
            mem_wdata = dWdata_q;
         end
         I_REQ: begin
            mem_req   = iPend_q;
            mem_addr  = iAddr_q;
         end
         default: ;
      endcase
   end

   assign mem_stall       = (state_q != IDLE);
   assign inst_sram_rdata = instRdata_q;
   assign data_sram_rdata = dataRdata_q;

   // Capture of core requests in IDLE and collection of responses in the
   // WAIT states. A response is taken only in a WAIT state, so a stray
   // mem_data_ok in IDLE or a REQ state has no effect. A store response
   // only completes the access and leaves the load result untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         dPend_q     <= 1'b0;
         iPend_q     <= 1'b0;
         dAddr_q     <= '0;
         dWen_q      <= '0;
         dWdata_q    <= '0;
         iAddr_q     <= '0;
         instRdata_q <= '0;
         dataRdata_q <= '0;
`ifdef BRIDGE_IBUF_EN
         ibValid_q   <= 1'b0;
         ibTag_q     <= '0;
         ibData_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               dPend_q <= data_sram_en;
               iPend_q <= fetchToMem;
               if (data_sram_en) begin
                  dAddr_q  <= data_sram_addr;
                  dWen_q   <= data_sram_wen;
                  dWdata_q <= data_sram_wdata;
               end
               if (fetchToMem) begin
                  iAddr_q <= inst_sram_addr;
               end
`ifdef BRIDGE_IBUF_EN
               if (ibHit) begin
                  instRdata_q <= ibData_q;
               end
               if (storeHitsTag) begin
                  ibValid_q <= 1'b0;
               end
`endif
            end
            D_WAIT: begin
               if (mem_data_ok) begin
                  dPend_q <= 1'b0;
                  if (dWen_q == '0) begin
                     dataRdata_q <= mem_rdata;
                  end
               end
            end
            I_WAIT: begin
               if (mem_data_ok) begin
                  iPend_q     <= 1'b0;
                  instRdata_q <= mem_rdata;
`ifdef BRIDGE_IBUF_EN
                  ibValid_q   <= 1'b1;
                  ibTag_q     <= iAddr_q[ADDR_W-1:2];
                  ibData_q    <= mem_rdata;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Bridges the core's two single-ported SRAM-style interfaces (`inst_sram_*`, `data_sram_*`) onto one shared memory port with a request/address-ok/data-ok handshake. It sits directly downstream of `mycpu_top`. It serialises each cycle's fetch and data access, data first. It holds the core with `mem_stall` until both results are returned.

## Interface
Parameters:
- `ADDR_W`, 32, address width on both sides
- `DATA_W`, 32, data width; strobe width is DATA_W/8

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `inst_sram_en`  in  1  fetch request
- `inst_sram_addr`  in  ADDR_W  fetch address
- `inst_sram_rdata`  out  DATA_W  fetched word, registered
- `data_sram_en`  in  1  data request
- `data_sram_wen`  in  4  byte strobes; non-zero means store
- `data_sram_addr`  in  ADDR_W  data address
- `data_sram_wdata`  in  DATA_W  store data
- `data_sram_rdata`  out  DATA_W  load result, registered
- `mem_stall`  out  1  core must freeze all pipeline registers
- `mem_req`  out  1  memory request valid
- `mem_wr`  out  1  1 = write
- `mem_wstrb`  out  4  byte strobes
- `mem_addr`  out  ADDR_W  request address
- `mem_wdata`  out  DATA_W  write data
- `mem_addr_ok`  in  1  request accepted this cycle
- `mem_data_ok`  in  1  response valid this cycle
- `mem_rdata`  in  DATA_W  response data

## Operation
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT.
- **IDLE capture.** In IDLE, requests are captured into internal registers at the clock edge, each with a pending bit: the data request when `data_sram_en`=1, the fetch request when `inst_sram_en`=1.
  - Next state is D_REQ if a data request is pending, else I_REQ if a fetch is pending, else IDLE.
- **D_REQ / I_REQ.**
  - `mem_req`=1 with the captured address, strobes and data; for fetches `mem_wr`=0 and `mem_wstrb`=0.
  - The request is held stable until the cycle with `mem_addr_ok`=1, then the state moves to the matching WAIT state.
- **D_WAIT / I_WAIT.**
  - `mem_req`=0.
  - On `mem_data_ok`=1 a read's `mem_rdata` is latched into the matching rdata register. A write's response only completes the access.
  - After D_WAIT the next state is I_REQ if a fetch is pending, else IDLE. After I_WAIT the next state is IDLE.
- **Outputs.**
  - `mem_stall` = (state != IDLE).
  - The rdata registers hold their value until overwritten by a later read. A store leaves `data_sram_rdata` unchanged.
- Only one memory transaction is outstanding at any time. `mem_data_ok` arriving in IDLE or in a REQ state is ignored.
- Reset: state IDLE; pending bits cleared; `mem_req`, `mem_wr`, `mem_stall` = 0; `mem_wstrb`, `mem_addr`, `mem_wdata`, both rdata outputs = 0.
- Reset mid-transaction returns to IDLE immediately and drops the in-flight access. The memory side shares `reset`, so no drain is performed.

## Timing
- Requests are captured at edge N. `mem_stall` is high from cycle N+1 until the cycle the final `mem_data_ok` is seen, inclusive.
- Result data is valid on the rdata outputs from the first cycle `mem_stall` is low.
- With zero wait states (`mem_addr_ok` in the first REQ cycle, `mem_data_ok` one cycle later):
  - fetch only: stall for 2 cycles (N+1..N+2);
  - fetch plus data: stall for 4 cycles (N+1..N+4).
- `mem_addr_ok` and `mem_data_ok` for the same transaction never occur in the same cycle; the bridge ignores `mem_data_ok` while in a REQ state.
- Core inputs are sampled only in IDLE; values presented while stalled are ignored.

## Configuration
- `BRIDGE_IBUF_EN` defined: adds a one-entry fetch buffer holding a valid bit, the tag (word address) and the instruction.
  - A fetch whose word address matches a valid tag is served from the buffer at capture and generates no memory access. A fetch-only hit causes no stall.
  - Each completed I_WAIT fills the buffer.
  - A store whose word address equals the tag clears the valid bit when captured.
  - Reset clears the valid bit.
- Not defined: every fetch goes to memory; no buffer state exists.

## Test plan
- Reset with `inst_sram_en`=1 held → `mem_req`=0, `mem_stall`=0, both rdata outputs 0x00000000 until the cycle after `reset` falls.
- Fetch 0xBFC00000, memory returns 0x3C010001 with zero wait → `mem_stall` high for exactly 2 cycles; `inst_sram_rdata`=0x3C010001 afterwards.
- Load 0x00001000 plus fetch 0xBFC00004 in the same cycle → data request issued first; `data_sram_rdata`=0xDEADBEEF and `inst_sram_rdata`=0x8C220000 after 4 stall cycles.
- Store `wen`=4'b0011 to 0x00000010, data 0x12345678, with `mem_addr_ok` delayed 3 cycles → `mem_req`, `mem_addr`, `mem_wstrb`=0011, `mem_wdata` stable for all 3 cycles; `data_sram_rdata` unchanged.
- Assert `reset` in D_WAIT, then raise a stray `mem_data_ok` in IDLE → state IDLE, rdata outputs 0, stray response ignored.
- With `BRIDGE_IBUF_EN`: fetch 0xBFC00008 twice → the second fetch makes no `mem_req` and causes no stall. Then store to 0xBFC00008 and fetch it again → the fetch goes to memory.
